// File: rtl/tnn_cmp_pipe_if.sv
// Handshake and payload bundle for the TNN comparator pipeline.
// The master drives operands, mode and downstream ready; the slave returns results.
interface tnn_cmp_pipe_if #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned VOTE_W = $clog2(CHANNELS + 1);
    localparam int unsigned CNT_W  = 16;

    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*WIDTH-1:0]    input_a;
    logic [CHANNELS*WIDTH-1:0]    input_b;
    logic                         mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS-1:0]          cgp_out;
    logic [VOTE_W-1:0]            vote_cnt;
    logic                         clear_stats;
    logic [CNT_W-1:0]             mismatch_cnt;

    modport master (
        output in_valid, input_a, input_b, mode, out_ready, clear_stats,
        input  in_ready, out_valid, cgp_out, vote_cnt, mismatch_cnt
    );

    modport slave (
        input  in_valid, input_a, input_b, mode, out_ready, clear_stats,
        output in_ready, out_valid, cgp_out, vote_cnt, mismatch_cnt
    );
endinterface

// File: rtl/tnn_cmp_pipe.sv
// Two-stage pipelined array of exact/approximate unsigned comparators with
// valid/ready flow control, per-transaction vote count and WCE mismatch counter.
module tnn_cmp_pipe #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TRUNC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    tnn_cmp_pipe_if.slave     bus
);
    localparam int unsigned VOTE_W  = $clog2(CHANNELS + 1);
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [VOTE_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [VOTE_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            c = c + VOTE_W'(v[i]);
        end
        return c;
    endfunction

    logic [CHANNELS-1:0] exact_c;
    logic [CHANNELS-1:0] approx_c;

    logic                s1_valid_q, s1_valid_d;
    logic [CHANNELS-1:0] s1_exact_q, s1_exact_d;
    logic [CHANNELS-1:0] s1_approx_q, s1_approx_d;
    logic                s1_mode_q, s1_mode_d;

    logic                s2_valid_q, s2_valid_d;
    logic [CHANNELS-1:0] cgp_q, cgp_d;
    logic [VOTE_W-1:0]   vote_q, vote_d;
    logic [VOTE_W-1:0]   s2_mm_q, s2_mm_d;
    logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d;

    logic                out_hs_c;
    logic                s2_load_c;
    logic                in_ready_c;
    logic                accept_c;
    logic [CNT_W:0]      mm_sum_c;
    logic [CHANNELS-1:0] sel_c;

    // Per-lane comparators; both flavours are always evaluated
    always_comb begin
        exact_c  = '0;
        approx_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            exact_c[i]  = bus.input_a[i*WIDTH +: WIDTH] >= bus.input_b[i*WIDTH +: WIDTH];
            approx_c[i] = (bus.input_a[i*WIDTH +: WIDTH] >> TRUNC)
                       >= (bus.input_b[i*WIDTH +: WIDTH] >> TRUNC);
        end
    end

    // Flow control: S1 may refill in the same cycle it hands over to S2
    always_comb begin
        out_hs_c   = s2_valid_q && bus.out_ready;
        s2_load_c  = s1_valid_q && (!s2_valid_q || out_hs_c);
        in_ready_c = !s1_valid_q || s2_load_c;
        accept_c   = bus.in_valid && in_ready_c;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_exact_d  = s1_exact_q;
        s1_approx_d = s1_approx_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        cgp_d       = cgp_q;
        vote_d      = vote_q;
        s2_mm_d     = s2_mm_q;
        mm_cnt_d    = mm_cnt_q;
        sel_c       = s1_mode_q ? s1_approx_q : s1_exact_q;
        mm_sum_c    = {1'b0, mm_cnt_q} + (CNT_W+1)'(s2_mm_q);

        if (accept_c) begin
            s1_valid_d  = 1'b1;
            s1_exact_d  = exact_c;
            s1_approx_d = approx_c;
            s1_mode_d   = bus.mode;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load_c) begin
            s2_valid_d = 1'b1;
            cgp_d      = sel_c;
            vote_d     = popcount(sel_c);
            s2_mm_d    = popcount(s1_exact_q ^ s1_approx_q);
        end else if (out_hs_c) begin
            s2_valid_d = 1'b0;
        end

        // Clear beats a same-cycle increment; the sum saturates instead of wrapping
        if (bus.clear_stats) begin
            mm_cnt_d = '0;
        end else if (out_hs_c) begin
            mm_cnt_d = mm_sum_c[CNT_W] ? CNT_MAX : mm_sum_c[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            s1_mode_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            cgp_q       <= '0;
            vote_q      <= '0;
            s2_mm_q     <= '0;
            mm_cnt_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_exact_q  <= s1_exact_d;
            s1_approx_q <= s1_approx_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            cgp_q       <= cgp_d;
            vote_q      <= vote_d;
            s2_mm_q     <= s2_mm_d;
            mm_cnt_q    <= mm_cnt_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = s2_valid_q;
    assign bus.cgp_out      = cgp_q;
    assign bus.vote_cnt     = vote_q;
    assign bus.mismatch_cnt = mm_cnt_q;
endmodule

// File: tb/tb_tnn_cmp_pipe.sv
// Scoreboard bench for tnn_cmp_pipe: a negedge monitor predicts every output and
// the mismatch counter, scenario tasks add timing and boundary checks.
module tb_tnn_cmp_pipe;
    localparam int unsigned W  = 3;
    localparam int unsigned C  = 4;
    localparam int unsigned T  = 1;
    localparam int unsigned VW = 3;

    typedef struct {
        logic [C-1:0]  cgp;
        logic [VW-1:0] vote;
        int            mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tnn_cmp_pipe_if #(.WIDTH(W), .CHANNELS(C)) bus();

    tnn_cmp_pipe #(.WIDTH(W), .CHANNELS(C), .TRUNC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   out_count = 0;
    int   mm_model  = 0;
    bit   mon_en    = 1'b0;
    exp_t sb[$];

    function automatic exp_t model(input logic [C*W-1:0] a, input logic [C*W-1:0] b,
                                   input logic m);
        exp_t r;
        logic [C-1:0] e;
        logic [C-1:0] ap;
        int av, bv;
        r.mm = 0;
        r.vote = '0;
        for (int i = 0; i < C; i++) begin
            av = int'(a[i*W +: W]);
            bv = int'(b[i*W +: W]);
            e[i]  = (av >= bv);
            ap[i] = ((av >> T) >= (bv >> T));
            if (e[i] != ap[i]) r.mm++;
        end
        r.cgp = m ? ap : e;
        for (int i = 0; i < C; i++) r.vote = r.vote + VW'(r.cgp[i]);
        return r;
    endfunction

    // Monitor: prediction of outputs and counter, one edge ahead
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst) begin
                sb.delete();
                mm_model = 0;
            end else begin
                n_checks++;
                if (bus.mismatch_cnt !== 16'(mm_model)) begin
                    n_fail++;
                    $display("FAIL mon_mismatch_cnt: got %0d expected %0d at %0t",
                             bus.mismatch_cnt, mm_model, $time);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_unexpected_output: got cgp %b expected none at %0t",
                                 bus.cgp_out, $time);
                    end else begin
                        e = sb.pop_front();
                        out_count++;
                        if (bus.cgp_out !== e.cgp || bus.vote_cnt !== e.vote) begin
                            n_fail++;
                            $display("FAIL mon_output: got cgp %b vote %0d expected cgp %b vote %0d at %0t",
                                     bus.cgp_out, bus.vote_cnt, e.cgp, e.vote, $time);
                        end
                        if (bus.clear_stats) mm_model = 0;
                        else mm_model = (mm_model + e.mm > 65535) ? 65535 : mm_model + e.mm;
                    end
                end else if (bus.clear_stats) begin
                    mm_model = 0;
                end
                if (bus.in_valid && bus.in_ready)
                    sb.push_back(model(bus.input_a, bus.input_b, bus.mode));
            end
        end
    end

    task automatic set_vec(input logic [C*W-1:0] a, input logic [C*W-1:0] b, input logic m);
        bus.input_a = a;
        bus.input_b = b;
        bus.mode    = m;
    endtask

    function automatic logic [C*W-1:0] spread(input logic [C-1:0] p);
        logic [C*W-1:0] v;
        for (int i = 0; i < C; i++) v[i*W +: W] = p[i] ? 3'd5 : 3'd2;
        return v;
    endfunction

    task automatic test_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear_stats = 1'b0;
        set_vec('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.cgp_out !== 4'b0) begin n_fail++; $display("FAIL reset_cgp_out: got %b expected 0000", bus.cgp_out); end
        n_checks++;
        if (bus.vote_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_vote_cnt: got %0d expected 0", bus.vote_cnt); end
        n_checks++;
        if (bus.mismatch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_mismatch_cnt: got %0d expected 0", bus.mismatch_cnt); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_exact();
        bus.out_ready = 1'b1;
        set_vec({3'd7, 3'd2, 3'd5, 3'd3}, {3'd0, 3'd1, 3'd6, 3'd3}, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL exact_latency_early: got out_valid %b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cgp_out !== 4'b1101 || bus.vote_cnt !== 3'd3) begin
            n_fail++;
            $display("FAIL exact_result: got valid %b cgp %b vote %0d expected 1 1101 3",
                     bus.out_valid, bus.cgp_out, bus.vote_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.mismatch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL exact_after_hs: got valid %b mismatch %0d expected 0 0",
                     bus.out_valid, bus.mismatch_cnt);
        end
    endtask

    task automatic test_approx();
        set_vec({3'd7, 3'd0, 3'd2, 3'd4}, {3'd6, 3'd1, 3'd3, 3'd5}, 1'b1);
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cgp_out !== 4'b1111 || bus.vote_cnt !== 3'd4
            || bus.mismatch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL approx_result: got valid %b cgp %b vote %0d mm %0d expected 1 1111 4 0",
                     bus.out_valid, bus.cgp_out, bus.vote_cnt, bus.mismatch_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.mismatch_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL approx_mismatch_inc: got %0d expected 3", bus.mismatch_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [C-1:0]   pats [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b1001};
        logic [C*W-1:0] bvec = {3'd4, 3'd4, 3'd4, 3'd4};
        int k = 0;
        int base = out_count;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            set_vec(spread(pats[k]), bvec, 1'(k % 2));
            @(negedge clk);
            if (bus.in_ready) k++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (k !== 2 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_capacity: got accepted %0d in_ready %b expected 2 0", k, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (k < 6) begin
                bus.in_valid = 1'b1;
                set_vec(spread(pats[k]), bvec, 1'(k % 2));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (k !== 6 || out_count - base !== 6 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got accepted %0d outputs %0d valid %b expected 6 6 0",
                     k, out_count - base, bus.out_valid);
        end
    endtask

    task automatic test_saturation_clear();
        bus.out_ready = 1'b1;
        set_vec({3'd7, 3'd0, 3'd2, 3'd4}, {3'd6, 3'd1, 3'd3, 3'd5}, 1'b1);
        bus.in_valid = 1'b1;
        repeat (21846) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mismatch_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: got %0d expected 65535", bus.mismatch_cnt);
        end
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.mismatch_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d expected 65535", bus.mismatch_cnt);
        end
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_setup: got out_valid %b expected 1", bus.out_valid);
        end
        bus.clear_stats = 1'b1;
        @(posedge clk); #1 bus.clear_stats = 1'b0;
        n_checks++;
        if (bus.mismatch_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_with_hs: got mm %0d valid %b expected 0 0",
                     bus.mismatch_cnt, bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        set_vec({3'd1, 3'd1, 3'd1, 3'd1}, {3'd0, 3'd0, 3'd0, 3'd0}, 1'b0);
        @(posedge clk); #1;
        set_vec({3'd0, 3'd0, 3'd0, 3'd1}, {3'd1, 3'd1, 3'd1, 3'd0}, 1'b0);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_setup: got valid %b in_ready %b expected 1 0",
                     bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.cgp_out !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_flush: got valid %b in_ready %b cgp %b expected 0 1 0000",
                     bus.out_valid, bus.in_ready, bus.cgp_out);
        end
        bus.out_ready = 1'b1;
        set_vec({3'd7, 3'd2, 3'd5, 3'd3}, {3'd0, 3'd1, 3'd6, 3'd3}, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_early: got out_valid %b expected 0", bus.out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.cgp_out !== 4'b1101) begin
            n_fail++;
            $display("FAIL midrst_next: got valid %b cgp %b expected 1 1101",
                     bus.out_valid, bus.cgp_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_approx();
        test_backpressure();
        test_saturation_clear();
        test_reset_midflight();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
